// File: rtl/pu_dispatch_ctrl.sv
// Job scheduler between the master core and the slave PUs: queues launch jobs,
// sets up the shared PU bus, pulses a one-hot start and tracks per-PU busy.
module pu_dispatch_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SEG_W      = 8,
  parameter int unsigned NUM_PU     = 7,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [SEG_W-1:0]              job_sa,
  input  logic [SEG_W-1:0]              job_sb,
  input  logic [SEG_W-1:0]              job_sc,
  input  logic [DATA_W-1:0]             job_ip,
  input  logic                          flush,
  input  logic [NUM_PU-1:0]             pu_en,
  input  logic [NUM_PU-1:0]             pu_int,
  output logic [SEG_W-1:0]              PU_SA,
  output logic [SEG_W-1:0]              PU_SB,
  output logic [SEG_W-1:0]              PU_SC,
  output logic [DATA_W-1:0]             PU_IP,
  output logic [NUM_PU-1:0]             pu_start,
  output logic [NUM_PU-1:0]             pu_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [DATA_W-1:0]             cpu_stat,
  output logic                          all_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 3*SEG_W + DATA_W;

  typedef enum logic [1:0] {IDLE, SETUP, START} state_t;

  state_t              state, state_nxt;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count, count_nxt;
  logic [NUM_PU-1:0]   busy, busy_nxt, en_q, target, free, lowest;
  logic                push, pop, latch;

  assign free      = pu_en & ~busy;
  // Isolates the lowest set bit of free.
  assign lowest    = free & (~free + NUM_PU'(1));
  assign job_ready = (count != (AW+1)'(FIFO_DEPTH));
  assign push      = job_valid & job_ready & ~flush;

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0 && |free && !flush) begin
          latch     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (flush || !(|(free & target))) state_nxt = IDLE;
        else                              state_nxt = START;
      end
      START: begin
        pop       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign count_nxt = flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  // Set wins over clear: a committed start always marks its target busy.
  assign busy_nxt  = (busy & ~(pu_int | (en_q & ~pu_en))) | (pop ? target : '0);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {job_sa, job_sb, job_sc, job_ip};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      busy     <= '0;
      en_q     <= '0;
      target   <= '0;
      PU_SA    <= '0;
      PU_SB    <= '0;
      PU_SC    <= '0;
      PU_IP    <= '0;
      all_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      busy     <= busy_nxt;
      en_q     <= pu_en;
      all_done <= (busy != '0) && (busy_nxt == '0) && (count_nxt == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (latch) begin
        {PU_SA, PU_SB, PU_SC, PU_IP} <= mem[rd_ptr];
        target                       <= lowest;
      end
    end
  end

  assign pu_start   = (state == START) ? target : '0;
  assign pu_busy    = busy;
  assign fifo_count = count;
  assign cpu_stat   = DATA_W'(busy);

endmodule

// File: tb/tb_pu_dispatch_ctrl.sv
// Bench for pu_dispatch_ctrl: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_pu_dispatch_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       job_valid = 1'b0;
  logic       job_ready;
  logic [7:0] job_sa = '0, job_sb = '0, job_sc = '0, job_ip = '0;
  logic       flush = 1'b0;
  logic [6:0] pu_en = '0, pu_int = '0;
  logic [7:0] PU_SA, PU_SB, PU_SC, PU_IP;
  logic [6:0] pu_start, pu_busy;
  logic [2:0] fifo_count;
  logic [7:0] cpu_stat;
  logic       all_done;

  pu_dispatch_ctrl #(.DATA_W(8), .SEG_W(8), .NUM_PU(7), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .job_valid(job_valid), .job_ready(job_ready),
    .job_sa(job_sa), .job_sb(job_sb), .job_sc(job_sc), .job_ip(job_ip),
    .flush(flush), .pu_en(pu_en), .pu_int(pu_int),
    .PU_SA(PU_SA), .PU_SB(PU_SB), .PU_SC(PU_SC), .PU_IP(PU_IP),
    .pu_start(pu_start), .pu_busy(pu_busy), .fifo_count(fifo_count),
    .cpu_stat(cpu_stat), .all_done(all_done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] sa, sb, sc, ip;
  } job_t;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  // Reference model: job queue, launch progress (0 none, 1 bus set up, 2 starting).
  job_t       q[$];
  int         m_phase;
  logic [6:0] m_tgt, m_busy, m_en_prev;
  job_t       m_bus;
  logic       m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] lowest_of(input logic [6:0] f);
    logic [6:0] r = '0;
    for (int i = 0; i < 7; i++) begin
      if (f[i]) begin
        r[i] = 1'b1;
        break;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_phase   = 0;
    m_tgt     = '0;
    m_busy    = '0;
    m_en_prev = '0;
    m_bus     = '0;
    m_done    = 1'b0;
  endtask

  task automatic model_update();
    logic [6:0] free, nb;
    logic       do_push, commit;
    free    = pu_en & ~m_busy;
    do_push = job_valid && (q.size() < 4) && !flush;
    commit  = 1'b0;
    case (m_phase)
      0: if (q.size() > 0 && free != 0 && !flush) begin
           m_tgt   = lowest_of(free);
           m_bus   = q[0];
           m_phase = 1;
         end
      1: m_phase = (flush || (free & m_tgt) == 0) ? 0 : 2;
      default: begin
        commit  = 1'b1;
        m_phase = 0;
      end
    endcase
    nb = m_busy & ~pu_int & ~(m_en_prev & ~pu_en);
    if (commit) begin
      nb = nb | m_tgt;
      void'(q.pop_front());
    end
    if (flush) q.delete();
    if (do_push) q.push_back({job_sa, job_sb, job_sc, job_ip});
    m_done    = (m_busy != 0) && (nb == 0) && (q.size() == 0);
    m_busy    = nb;
    m_en_prev = pu_en;
  endtask

  task automatic check_all();
    chk("job_ready", job_ready, q.size() < 4);
    chk("fifo_count", fifo_count, q.size());
    chk("pu_start", pu_start, (m_phase == 2) ? m_tgt : 7'h00);
    chk("pu_busy", pu_busy, m_busy);
    chk("cpu_stat", cpu_stat, {1'b0, m_busy});
    chk("pu_bus", {PU_SA, PU_SB, PU_SC, PU_IP}, m_bus);
    chk("all_done", all_done, m_done);
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RESET) model_reset();
    else        model_update();
    #1;
    check_all();
  endtask

  task automatic rand_inputs();
    job_valid = 1'($urandom_range(0, 1));
    job_sa    = 8'($urandom);
    job_sb    = 8'($urandom);
    job_sc    = 8'($urandom);
    job_ip    = 8'($urandom);
    flush     = ($urandom_range(0, 39) == 0);
    for (int i = 0; i < 7; i++) pu_int[i] = ($urandom_range(0, 5) == 0);
    if ($urandom_range(0, 11) == 0) pu_en[$urandom_range(0, 6)] ^= 1'b1;
    if (m_phase == 2) pu_en = pu_en | m_tgt;
  endtask

  task automatic idle_inputs();
    job_valid = 1'b0;
    flush     = 1'b0;
    pu_int    = '0;
  endtask

  initial begin
    bit got_start;
    model_reset();
    tick();
    tick();
    RESET = 1'b1;

    // Single job, latency and first target.
    pu_en = 7'h7F;
    job_valid = 1'b1;
    {job_sa, job_sb, job_sc, job_ip} = {8'd1, 8'd2, 8'd3, 8'h40};
    tick();
    job_valid = 1'b0;
    tick();
    chk("t1_nostart", pu_start, 7'h00);
    tick();
    chk("t1_start", pu_start, 7'h01);
    chk("t1_ip", PU_IP, 8'h40);
    tick();
    chk("t1_busy", pu_busy, 7'h01);
    chk("t1_start_off", pu_start, 7'h00);

    // Second job to PU2, then both interrupt together.
    job_valid = 1'b1;
    {job_sa, job_sb, job_sc, job_ip} = {8'd9, 8'd8, 8'd7, 8'h55};
    tick();
    job_valid = 1'b0;
    repeat (3) tick();
    chk("t6_busy", pu_busy, 7'h03);
    pu_int = 7'h03;
    tick();
    pu_int = '0;
    chk("t6_busy0", pu_busy, 7'h00);
    chk("t6_done", all_done, 1'b1);
    chk("t6_stat", cpu_stat, 8'h00);
    tick();
    chk("t6_done_pulse", all_done, 1'b0);

    // Fill with no PU enabled; 5th and 6th offers refused.
    pu_en = '0;
    job_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      {job_sa, job_sb, job_sc, job_ip} = {8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 64)};
      tick();
    end
    chk("t3_count", fifo_count, 3'd4);
    chk("t3_ready", job_ready, 1'b0);

    // Target disabled during setup: no start, job reissued on next free PU.
    job_valid = 1'b0;
    pu_en = 7'h02;
    tick();
    pu_en = 7'h04;
    tick();
    chk("t4_nostart", pu_start, 7'h00);
    chk("t4_count", fifo_count, 3'd4);
    tick();
    tick();
    chk("t4_start", pu_start, 7'h04);
    chk("t4_ip", PU_IP, 8'd64);
    pu_en = 7'h7F;
    repeat (20) tick();

    // Async reset while a start pulse is high.
    got_start = 1'b0;
    for (int c = 0; c < 300 && !got_start; c++) begin
      rand_inputs();
      tick();
      if (m_phase == 2) got_start = 1'b1;
    end
    chk("wait_start", got_start, 1'b1);
    RESET = 1'b0;
    #1;
    model_reset();
    chk("rst_start", pu_start, 7'h00);
    check_all();
    @(negedge CLK);
    RESET = 1'b1;
    pu_en = 7'h7F;

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      tick();
    end
    idle_inputs();
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
